// File: rtl/vtg_pkg.sv
// Shared timing defaults, pattern encodings and colour-bar lookup for the
// LCD test-pattern generator.
package vtg_pkg;

  localparam int DEF_P_DAT_BIT = 6;
  localparam int DEF_H_ACT     = 480;
  localparam int DEF_H_FP      = 2;
  localparam int DEF_H_SYNC    = 41;
  localparam int DEF_H_BP      = 2;
  localparam int DEF_H_TOT     = DEF_H_ACT + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_ACT     = 272;
  localparam int DEF_V_FP      = 2;
  localparam int DEF_V_SYNC    = 10;
  localparam int DEF_V_BP      = 2;
  localparam int DEF_V_TOT     = DEF_V_ACT + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_BAR_W     = 60;
  localparam int DEF_RAMP_SH   = 3;

  typedef enum logic [1:0] {
    PAT_BARS   = 2'd0,
    PAT_RAMP   = 2'd1,
    PAT_CHECK  = 2'd2,
    PAT_BORDER = 2'd3
  } pat_e;

  // {r,g,b} full-scale enables: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return {~idx[1], ~idx[2], ~idx[0]};
  endfunction

endpackage

// File: rtl/vtg_counter.sv
// Horizontal/vertical pixel counters with synchronous enable clear, plus
// combinational de/hs/vs/frame-start decode of the current count.
module vtg_counter
  import vtg_pkg::*;
#(
  parameter int H_ACT  = DEF_H_ACT,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_ACT  = DEF_V_ACT,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic       clk,
  input  logic       xrst,
  input  logic       en,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       h_last,
  output logic       de,
  output logic       hs,
  output logic       vs,
  output logic       fs
);

  localparam logic [9:0] H_ACT_C = 10'(H_ACT);
  localparam logic [9:0] HS_BEG  = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST  = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_C = 10'(V_ACT);
  localparam logic [9:0] VS_BEG  = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST  = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);

  assign h_last = (hcnt == H_LAST);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  assign de = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
  assign hs = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign fs = (hcnt == 10'd0) && (vcnt == 10'd0);

endmodule

// File: rtl/vtg_pattern.sv
// 480x272 panel timing and RGB test-pattern source; all outputs are registered
// one clk after the counter state they describe, no backpressure (free-running).
module vtg_pattern
  import vtg_pkg::*;
#(
  parameter int P_DAT_BIT = DEF_P_DAT_BIT,
  parameter int H_ACT     = DEF_H_ACT,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACT     = DEF_V_ACT,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int BAR_W     = DEF_BAR_W,
  parameter int RAMP_SH   = DEF_RAMP_SH
) (
  input  logic                 clk,
  input  logic                 xrst,
  input  logic                 en,
  input  logic [1:0]           pat_sel,
  output logic                 vs_out,
  output logic                 hs_out,
  output logic                 de_out,
  output logic [P_DAT_BIT-1:0] rdata_out,
  output logic [P_DAT_BIT-1:0] gdata_out,
  output logic [P_DAT_BIT-1:0] bdata_out,
  output logic                 frame_start
);

  localparam logic [9:0] H_END_C  = 10'(H_ACT - 1);
  localparam logic [9:0] V_END_C  = 10'(V_ACT - 1);
  localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

  logic [9:0] hcnt, vcnt;
  logic       h_last, de, hs, vs, fs;

  vtg_counter #(
    .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_cnt (
    .clk    (clk),
    .xrst   (xrst),
    .en     (en),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .h_last (h_last),
    .de     (de),
    .hs     (hs),
    .vs     (vs),
    .fs     (fs)
  );

  // Pattern is sampled only at (0,0); the bypass lets the new choice paint that pixel too.
  pat_e pat_q, pat_cur;
  assign pat_cur = (en && fs) ? pat_e'(pat_sel) : pat_q;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)
      pat_q <= PAT_BARS;
    else if (en && fs)
      pat_q <= pat_e'(pat_sel);
  end

  // Bar index tracks hcnt without a divider; it is cleared whenever hcnt returns to 0.
  logic [2:0] bar_idx;
  logic [9:0] bar_px;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      bar_idx <= '0;
      bar_px  <= '0;
    end else if (!en || h_last) begin
      bar_idx <= '0;
      bar_px  <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px <= '0;
      if (bar_idx != 3'd7)
        bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px <= bar_px + 10'd1;
    end
  end

  logic [2:0]           bar_on;
  logic [P_DAT_BIT-1:0] pix_r, pix_g, pix_b, ramp;

  always_comb begin
    bar_on = bar_rgb(bar_idx);
    ramp   = P_DAT_BIT'(hcnt >> RAMP_SH);
    pix_r  = '0;
    pix_g  = '0;
    pix_b  = '0;
    case (pat_cur)
      PAT_BARS: begin
        pix_r = {P_DAT_BIT{bar_on[2]}};
        pix_g = {P_DAT_BIT{bar_on[1]}};
        pix_b = {P_DAT_BIT{bar_on[0]}};
      end
      PAT_RAMP: begin
        pix_r = ramp;
        pix_g = ramp;
        pix_b = ramp;
      end
      PAT_CHECK: begin
        pix_r = {P_DAT_BIT{hcnt[4] ^ vcnt[4]}};
        pix_g = {P_DAT_BIT{hcnt[4] ^ vcnt[4]}};
        pix_b = {P_DAT_BIT{hcnt[4] ^ vcnt[4]}};
      end
      PAT_BORDER: begin
        pix_r = {P_DAT_BIT{(hcnt == 10'd0) || (hcnt == H_END_C) ||
                           (vcnt == 10'd0) || (vcnt == V_END_C)}};
        pix_g = pix_r;
        pix_b = pix_r;
      end
      default: begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst || !en) begin
      vs_out      <= 1'b0;
      hs_out      <= 1'b0;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
      rdata_out   <= '0;
      gdata_out   <= '0;
      bdata_out   <= '0;
    end else begin
      vs_out      <= vs;
      hs_out      <= hs;
      de_out      <= de;
      frame_start <= fs;
      rdata_out   <= de ? pix_r : '0;
      gdata_out   <= de ? pix_g : '0;
      bdata_out   <= de ? pix_b : '0;
    end
  end

endmodule

// File: tb/tb_vtg_pattern.sv
// Directed bench for vtg_pattern; vertical geometry is shortened so whole
// frames fit in a short run, horizontal geometry is the real 480/525 line.
module tb_vtg_pattern;

  localparam int TV_ACT  = 18;
  localparam int TV_FP   = 1;
  localparam int TV_SYNC = 2;
  localparam int TV_BP   = 1;
  localparam int HT      = 525;
  localparam int FRAME   = HT * (TV_ACT + TV_FP + TV_SYNC + TV_BP);

  localparam logic [17:0] C_WHITE = {6'h3F, 6'h3F, 6'h3F};
  localparam logic [17:0] C_YEL   = {6'h3F, 6'h3F, 6'h00};
  localparam logic [17:0] C_BLUE  = {6'h00, 6'h00, 6'h3F};
  localparam logic [17:0] C_BLACK = 18'h0;
  localparam logic [17:0] C_G12   = {6'd12, 6'd12, 6'd12};
  localparam logic [17:0] C_G59   = {6'd59, 6'd59, 6'd59};

  logic       clk = 1'b0;
  logic       xrst;
  logic       en;
  logic [1:0] pat_sel;
  logic       vs_out, hs_out, de_out, frame_start;
  logic [5:0] rdata_out, gdata_out, bdata_out;

  int checks = 0;
  int errors = 0;

  vtg_pattern #(
    .V_ACT (TV_ACT), .V_FP (TV_FP), .V_SYNC (TV_SYNC), .V_BP (TV_BP)
  ) dut (
    .clk         (clk),
    .xrst        (xrst),
    .en          (en),
    .pat_sel     (pat_sel),
    .vs_out      (vs_out),
    .hs_out      (hs_out),
    .de_out      (de_out),
    .rdata_out   (rdata_out),
    .gdata_out   (gdata_out),
    .bdata_out   (bdata_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] cur_rgb();
    return {rdata_out, gdata_out, bdata_out};
  endfunction

  function automatic logic [3:0] cur_ctl();
    return {vs_out, hs_out, de_out, frame_start};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drop en long enough to clear the counters, then restart a fresh frame;
  // returns at the negedge where outputs describe pixel (0,0).
  task automatic restart(input logic [1:0] p);
    en = 1'b0;
    step(2);
    pat_sel = p;
    en = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    xrst = 1'b0; en = 1'b0; pat_sel = 2'd0;
    step(3);
    checks++; if (cur_ctl() !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b expected 0000", cur_ctl()); end
    checks++; if (cur_rgb() !== C_BLACK) begin errors++; $display("FAIL reset_rgb: got %h expected %h", cur_rgb(), C_BLACK); end
  endtask

  task automatic test_timing();
    int de_line0 = 0, hs_first = -1, hs_w = 0, de_rise1 = -1;
    int de_tot = 0, vs_tot = 0, vs_first = -1, fs_mid = 0;
    logic fs_end = 1'b0;
    xrst = 1'b1; en = 1'b1; pat_sel = 2'd0;
    step(1);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_fs: got %b expected 1", frame_start); end
    checks++; if (de_out !== 1'b1) begin errors++; $display("FAIL first_de: got %b expected 1", de_out); end
    for (int i = 0; i <= FRAME; i++) begin
      if (i < FRAME) begin
        if (de_out) de_tot++;
        if (vs_out) begin vs_tot++; if (vs_first < 0) vs_first = i; end
        if (i < HT) begin
          if (de_out) de_line0++;
          if (hs_out) begin hs_w++; if (hs_first < 0) hs_first = i; end
        end else if (de_rise1 < 0 && de_out) begin
          de_rise1 = i;
        end
        if (i > 0 && frame_start) fs_mid++;
        step(1);
      end else begin
        fs_end = frame_start;
      end
    end
    checks++; if (de_line0 !== 480) begin errors++; $display("FAIL de_width: got %0d expected 480", de_line0); end
    checks++; if (hs_first !== 482) begin errors++; $display("FAIL hs_offset: got %0d expected 482", hs_first); end
    checks++; if (hs_w !== 41) begin errors++; $display("FAIL hs_width: got %0d expected 41", hs_w); end
    checks++; if (de_rise1 !== 525) begin errors++; $display("FAIL line_period: got %0d expected 525", de_rise1); end
    checks++; if (de_tot !== 18 * 480) begin errors++; $display("FAIL de_total: got %0d expected %0d", de_tot, 18 * 480); end
    checks++; if (vs_first !== 19 * HT) begin errors++; $display("FAIL vs_start: got %0d expected %0d", vs_first, 19 * HT); end
    checks++; if (vs_tot !== 2 * HT) begin errors++; $display("FAIL vs_width: got %0d expected %0d", vs_tot, 2 * HT); end
    checks++; if (fs_mid !== 0) begin errors++; $display("FAIL fs_extra: got %0d expected 0", fs_mid); end
    checks++; if (fs_end !== 1'b1) begin errors++; $display("FAIL fs_next_frame: got %b expected 1", fs_end); end
  endtask

  task automatic test_bars();
    int bad_black = 0;
    restart(2'd0);
    for (int i = 0; i < 480; i++) begin
      if (i == 0) begin
        checks++; if (cur_rgb() !== C_WHITE) begin errors++; $display("FAIL bar_px0: got %h expected %h", cur_rgb(), C_WHITE); end
      end
      if (i == 60) begin
        checks++; if (cur_rgb() !== C_YEL) begin errors++; $display("FAIL bar_px60: got %h expected %h", cur_rgb(), C_YEL); end
      end
      if (i == 419) begin
        checks++; if (cur_rgb() !== C_BLUE) begin errors++; $display("FAIL bar_px419: got %h expected %h", cur_rgb(), C_BLUE); end
      end
      if (i >= 420 && cur_rgb() !== C_BLACK) bad_black++;
      step(1);
    end
    checks++; if (bad_black !== 0) begin errors++; $display("FAIL bar_black: got %0d non-black expected 0", bad_black); end
  endtask

  task automatic test_ramp();
    restart(2'd1);
    step(100);
    checks++; if (cur_rgb() !== C_G12) begin errors++; $display("FAIL ramp_px100: got %h expected %h", cur_rgb(), C_G12); end
    step(379);
    checks++; if (cur_rgb() !== C_G59) begin errors++; $display("FAIL ramp_px479: got %h expected %h", cur_rgb(), C_G59); end
  endtask

  task automatic test_checker();
    restart(2'd2);
    checks++; if (cur_rgb() !== C_BLACK) begin errors++; $display("FAIL chk_0_0: got %h expected %h", cur_rgb(), C_BLACK); end
    step(16);
    checks++; if (cur_rgb() !== C_WHITE) begin errors++; $display("FAIL chk_16_0: got %h expected %h", cur_rgb(), C_WHITE); end
    step(16 * HT);
    checks++; if (cur_rgb() !== C_BLACK) begin errors++; $display("FAIL chk_16_16: got %h expected %h", cur_rgb(), C_BLACK); end
  endtask

  task automatic test_border();
    int bad0 = 0, bad_blank = 0, bad1 = 0;
    restart(2'd3);
    for (int i = 0; i < HT + 480; i++) begin
      if (i < 480) begin
        if (cur_rgb() !== C_WHITE) bad0++;
      end else if (i < HT) begin
        if (cur_rgb() !== C_BLACK) bad_blank++;
      end else if (i == HT || i == HT + 479) begin
        if (cur_rgb() !== C_WHITE) bad1++;
      end else begin
        if (cur_rgb() !== C_BLACK) bad1++;
      end
      step(1);
    end
    checks++; if (bad0 !== 0) begin errors++; $display("FAIL border_line0: got %0d bad pixels expected 0", bad0); end
    checks++; if (bad_blank !== 0) begin errors++; $display("FAIL blank_rgb: got %0d nonzero expected 0", bad_blank); end
    checks++; if (bad1 !== 0) begin errors++; $display("FAIL border_line1: got %0d bad pixels expected 0", bad1); end
    step((TV_ACT - 1) * HT + 200 - (HT + 480));
    checks++; if (cur_rgb() !== C_WHITE) begin errors++; $display("FAIL border_last_line: got %h expected %h", cur_rgb(), C_WHITE); end
  endtask

  task automatic test_pat_switch();
    restart(2'd0);
    step(10 * HT);
    pat_sel = 2'd1;
    step(2 * HT + 100);
    checks++; if (cur_rgb() !== C_YEL) begin errors++; $display("FAIL switch_same_frame: got %h expected %h", cur_rgb(), C_YEL); end
    step(FRAME - 12 * HT - 100);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL switch_fs: got %b expected 1", frame_start); end
    step(100);
    checks++; if (cur_rgb() !== C_G12) begin errors++; $display("FAIL switch_next_frame: got %h expected %h", cur_rgb(), C_G12); end
  endtask

  task automatic test_en();
    restart(2'd0);
    step(HT + 200);
    checks++; if (de_out !== 1'b1) begin errors++; $display("FAIL en_pre_de: got %b expected 1", de_out); end
    en = 1'b0;
    step(1);
    checks++; if ({cur_ctl(), cur_rgb()} !== 22'h0) begin errors++; $display("FAIL en_off: got %h expected 0", {cur_ctl(), cur_rgb()}); end
    step(5);
    checks++; if ({cur_ctl(), cur_rgb()} !== 22'h0) begin errors++; $display("FAIL en_held: got %h expected 0", {cur_ctl(), cur_rgb()}); end
    en = 1'b1;
    step(1);
    checks++; if ({frame_start, de_out, cur_rgb()} !== {2'b11, C_WHITE}) begin errors++; $display("FAIL en_restart: got %h expected %h", {frame_start, de_out, cur_rgb()}, {2'b11, C_WHITE}); end
    step(1);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL en_fs_pulse: got %b expected 0", frame_start); end
    step(59);
    checks++; if (cur_rgb() !== C_YEL) begin errors++; $display("FAIL en_px60: got %h expected %h", cur_rgb(), C_YEL); end
  endtask

  task automatic test_reset_mid();
    restart(2'd1);
    step(HT + 50);
    #2 xrst = 1'b0;
    #1;
    checks++; if ({cur_ctl(), cur_rgb()} !== 22'h0) begin errors++; $display("FAIL mid_reset: got %h expected 0", {cur_ctl(), cur_rgb()}); end
    @(negedge clk);
    xrst = 1'b1;
    pat_sel = 2'd0;
    step(1);
    checks++; if ({frame_start, de_out, cur_rgb()} !== {2'b11, C_WHITE}) begin errors++; $display("FAIL mid_reset_resume: got %h expected %h", {frame_start, de_out, cur_rgb()}, {2'b11, C_WHITE}); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_ramp();
    test_checker();
    test_border();
    test_pat_switch();
    test_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
